// File: rtl/apb_slave_regbank.sv
// APB responder serving an 8-word register bank: six R/W words, an ID word and a STATUS word.
// Read data is preloaded on setup entry; writes commit on the setup-to-access edge.
module apb_slave_regbank #(
    parameter int unsigned SEL_INDEX = 0,
    parameter int unsigned ADDR_LSB  = 2,
    parameter logic [31:0] ID_VALUE  = 32'hA0B0_0001
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        proto_err,
    output logic [7:0]  wr_count,
    output logic        xfer_done
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        pwrite_q;
    logic [31:0] regs_q [6];
    logic [31:0] prdata_q;
    logic        proto_err_q;
    logic [7:0]  wr_count_q;
    logic        xfer_done_q;

    logic        sel, oor, match;
    logic [2:0]  idx;
    logic        latch, commit, set_err;
    logic        reg_wr, status_clr;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign sel         = psel[SEL_INDEX];
    assign idx         = paddr[ADDR_LSB+2:ADDR_LSB];
    assign oor         = |paddr[31:ADDR_LSB+3];
    assign match       = (paddr == addr_q) && (pwrite == pwrite_q);
    assign unused_bits = ^{psel, paddr};

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        commit  = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel && !penable) begin
                    state_d = StSetup;
                    latch   = 1'b1;
                end else if (sel && penable) begin
                    set_err = 1'b1;
                end
            end
            StSetup: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (!penable) begin
                    latch = 1'b1;
                end else if (match) begin
                    state_d = StAccess;
                    commit  = 1'b1;
                end else begin
                    state_d = StIdle;
                    set_err = 1'b1;
                end
            end
            StAccess: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (!penable) begin
                    state_d = StSetup;
                    latch   = 1'b1;
                end else begin
                    state_d = StIdle;
                    set_err = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Out-of-range and ID-register writes are silently dropped.
    assign reg_wr     = commit && pwrite_q && !oor && (idx <= 3'd5);
    assign status_clr = commit && pwrite_q && !oor && (idx == 3'd7) && pwdata[0];

    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) rd_word = regs_q[i];
        end
        if (idx == 3'd6) rd_word = ID_VALUE;
        if (idx == 3'd7) rd_word = {16'h0, wr_count_q, 7'h0, proto_err_q};
        if (oor) rd_word = 32'h0;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= StIdle;
            addr_q      <= 32'h0;
            pwrite_q    <= 1'b0;
            prdata_q    <= 32'h0;
            proto_err_q <= 1'b0;
            wr_count_q  <= 8'h0;
            xfer_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) regs_q[i] <= 32'h0;
        end else begin
            state_q     <= state_d;
            xfer_done_q <= commit;
            if (latch) begin
                addr_q   <= paddr;
                pwrite_q <= pwrite;
                if (!pwrite) prdata_q <= rd_word;
            end
            for (int i = 0; i < 6; i++) begin
                if (reg_wr && idx == 3'(i)) regs_q[i] <= pwdata;
            end
            if (status_clr)  wr_count_q <= 8'h0;
            else if (reg_wr) wr_count_q <= wr_count_q + 8'd1;
            // A violation on the same edge as a STATUS clear leaves the flag set.
            if (set_err)         proto_err_q <= 1'b1;
            else if (status_clr) proto_err_q <= 1'b0;
        end
    end

    assign prdata    = prdata_q;
    assign proto_err = proto_err_q;
    assign wr_count  = wr_count_q;
    assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized bench for two register-bank instances on one APB bus (psel bits 0 and 1),
// checked against an array-based model of the register map.
module tb_apb_slave_regbank;

    logic             hclk = 1'b0;
    logic             hreset;
    logic [2:0]       psel;
    logic             penable, pwrite;
    logic [31:0]      paddr, pwdata;
    logic [1:0][31:0] prdata_v;
    logic [1:0][7:0]  cnt_v;
    logic [1:0]       perr_v, xdone_v;

    localparam logic [31:0] IdVal = 32'hA0B0_0001;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur     = 0;
    logic [31:0] mregs [2][6];
    int          mcount [2];
    logic        merr [2];

    always #5 hclk = ~hclk;

    apb_slave_regbank #(.SEL_INDEX(0), .ADDR_LSB(2), .ID_VALUE(IdVal)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .proto_err(perr_v[0]),
        .wr_count(cnt_v[0]), .xfer_done(xdone_v[0])
    );

    apb_slave_regbank #(.SEL_INDEX(1), .ADDR_LSB(2), .ID_VALUE(IdVal)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .proto_err(perr_v[1]),
        .wr_count(cnt_v[1]), .xfer_done(xdone_v[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%08h exp=%08h t=%0t", tag, cur, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) mregs[k][i] = 32'h0;
            mcount[k] = 0;
            merr[k]   = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int w;
        if (a[31:5] != 27'h0) return 32'h0;
        w = int'(a[4:2]);
        if (w < 6) return mregs[cur][w];
        if (w == 6) return IdVal;
        return {16'h0, 8'(mcount[cur]), 7'h0, merr[cur]};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        int w;
        if (a[31:5] != 27'h0) return;
        w = int'(a[4:2]);
        if (w < 6) begin
            mregs[cur][w] = d;
            mcount[cur]   = (mcount[cur] + 1) % 256;
        end else if (w == 7 && d[0]) begin
            mcount[cur] = 0;
            merr[cur]   = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        psel    = 3'b000;
        penable = 1'b0;
        step();
    endtask

    task automatic check_status();
        check_eq("wr_count", 32'(cnt_v[cur]), 32'(mcount[cur]));
        check_eq("proto_err", 32'(perr_v[cur]), 32'(merr[cur]));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        psel    = (cur == 1) ? 3'b010 : 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = d;
        step();
        penable = 1'b1;
        step();
        check_eq("wr_xfer_done", 32'(xdone_v[cur]), 32'h1);
        model_write(a, d);
        check_status();
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp;
        exp     = exp_read(a);
        psel    = (cur == 1) ? 3'b010 : 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = a;
        pwdata  = $urandom;
        step();
        penable = 1'b1;
        check_eq("rd_enable_cycle", prdata_v[cur], exp);
        step();
        check_eq("rd_xfer_done", 32'(xdone_v[cur]), 32'h1);
        check_eq("rd_hold", prdata_v[cur], exp);
    endtask

    task automatic viol_noset();
        bus_idle();
        psel    = (cur == 1) ? 3'b010 : 3'b001;
        penable = 1'b1;
        pwrite  = 1'($urandom);
        paddr   = {27'h0, 3'($urandom), 2'b00};
        pwdata  = $urandom;
        step();
        merr[cur] = 1'b1;
        check_eq("noset_no_done", 32'(xdone_v[cur]), 32'h0);
        check_status();
        bus_idle();
    endtask

    task automatic viol_addr(input logic [31:0] a);
        psel    = (cur == 1) ? 3'b010 : 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = $urandom;
        step();
        penable = 1'b1;
        paddr   = a ^ 32'h4;
        step();
        merr[cur] = 1'b1;
        check_eq("chg_no_done", 32'(xdone_v[cur]), 32'h0);
        check_status();
        bus_idle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[31:5] = 27'h0;
        else a[5] = 1'b1;
        return a;
    endfunction

    initial begin
        hreset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        model_reset();
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            cur = k;
            check_eq("rst_prdata", prdata_v[k], 32'h0);
            check_status();
            check_eq("rst_done", 32'(xdone_v[k]), 32'h0);
        end
        cur    = 0;
        hreset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) do_read(32'(i * 4));

        do_write(32'h08, 32'hDEAD_BEEF);
        do_read(32'h08);
        bus_idle();
        check_eq("done_single_pulse", 32'(xdone_v[0]), 32'h0);

        do_write(32'h04, 32'h11);
        do_write(32'h14, 32'h22);
        do_read(32'h04);
        do_read(32'h14);
        bus_idle();

        viol_noset();
        viol_addr(32'h0C);
        for (int i = 0; i < 8; i++) do_read(32'(i * 4));
        do_write(32'h1C, 32'h1);

        cur = 1;
        do_write(32'h0C, 32'h55);
        do_read(32'h0C);
        cur = 0;
        do_read(32'h0C);
        do_write(32'h40, 32'hFFFF_0000);
        do_write(32'h18, 32'h1234_5678);
        do_read(32'h40);
        do_read(32'h18);
        do_write(32'h1C, 32'h1);
        for (int i = 0; i < 256; i++) do_write(32'h00, 32'(i));
        check_eq("wrap_zero", 32'(cnt_v[0]), 32'h0);
        bus_idle();

        do_write(32'h10, 32'h1234);
        do_read(32'h10);
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h14;
        pwdata  = 32'h99;
        step();
        penable = 1'b1;
        #2 hreset = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        #1;
        model_reset();
        check_eq("arst_prdata", prdata_v[0], 32'h0);
        check_status();
        check_eq("arst_done", 32'(xdone_v[0]), 32'h0);
        #2 hreset = 1'b0;
        step();
        do_read(32'h14);
        do_write(32'h14, 32'h99);
        do_read(32'h14);
        bus_idle();

        for (int n = 0; n < 400; n++) begin
            int op;
            cur = ($urandom_range(0, 3) == 0) ? 1 : 0;
            op  = $urandom_range(0, 19);
            if (op < 8) do_write(rand_addr(), $urandom);
            else if (op < 16) do_read(rand_addr());
            else if (op == 16) viol_noset();
            else if (op == 17) viol_addr(rand_addr());
            else bus_idle();
            for (int k = 0; k < 2; k++) begin
                check_eq("bg_count", 32'(cnt_v[k]), 32'(mcount[k]));
                check_eq("bg_err", 32'(perr_v[k]), 32'(merr[k]));
            end
        end
        bus_idle();
        for (int k = 0; k < 2; k++) begin
            cur = k;
            for (int i = 0; i < 8; i++) do_read(32'(i * 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
